// File: rtl/dual_port_ram_pkg.sv
// Shared types and constants for the byte-enable dual-port RAM and its clear controller.
package dual_port_ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } clr_state_e;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear sequencer: walks every address once, one per cycle, and holds busy while doing so.
module ram_clear_ctrl #(
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   output logic                  busy,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr
);
   import dual_port_ram_pkg::*;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   clr_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

   // A clr request during a pass simply restarts it from address 0.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CLEAR: begin
            if (clr) begin
               cnt_d = '0;
            end else if (cnt_q == LAST_ADDR) begin
               state_d = READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         READY: begin
            if (clr) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy     = (state_q == CLEAR);
   assign clr_we   = busy;
   assign clr_addr = cnt_q;

endmodule

// File: rtl/dual_port_ram_be.sv
// Simple dual-port RAM with per-lane write enables, pipelined reads (latency 1 or 2),
// selectable read-during-write behaviour and a self-clearing array after reset or clr.
module dual_port_ram_be #(
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int RD_LATENCY = 1,
   parameter int RDW_MODE   = 0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             clr,
   output logic                             busy,
   input  logic                             wr_en,
   input  logic [ADDR_WIDTH-1:0]            wr_addr,
   input  logic [DATA_WIDTH-1:0]            wr_data,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
   input  logic                             rd_en,
   input  logic [ADDR_WIDTH-1:0]            rd_addr,
   output logic [DATA_WIDTH-1:0]            rd_data,
   output logic                             rd_valid,
   output logic                             collision
);
   import dual_port_ram_pkg::*;

   localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;

   ram_clear_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  wr_acc;
   logic                  rd_acc;
   logic                  hit;
   logic [DATA_WIDTH-1:0] old_word;
   logic [DATA_WIDTH-1:0] merged_word;
   logic [DATA_WIDTH-1:0] read_word;

   assign wr_acc = wr_en & ~busy;
   assign rd_acc = rd_en & ~busy;
   assign hit    = rd_acc & wr_acc & (wr_addr == rd_addr) & (|wr_be);

   // The merged word is only used in new-data mode; old mode always returns the stored word.
   always_comb begin
      old_word    = mem_q[rd_addr];
      merged_word = old_word;
      for (int i = 0; i < NB; i++) begin
         if (wr_be[i]) begin
            merged_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
      read_word = (RDW_MODE == RDW_NEW && hit) ? merged_word : old_word;
   end

   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem_q[clr_addr] <= '0;
      end else if (wr_acc) begin
         for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
               mem_q[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   logic                  s1_valid_q, s1_valid_d;
   logic                  s1_col_q, s1_col_d;
   logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

   always_comb begin
      s1_valid_d = rd_acc;
      s1_col_d   = hit;
      s1_data_d  = rd_acc ? read_word : s1_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_col_q   <= 1'b0;
         s1_data_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_col_q   <= s1_col_d;
         s1_data_q  <= s1_data_d;
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic                  s2_valid_q, s2_valid_d;
         logic                  s2_col_q, s2_col_d;
         logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

         always_comb begin
            s2_valid_d = s1_valid_q;
            s2_col_d   = s1_col_q;
            s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s2_valid_q <= 1'b0;
               s2_col_q   <= 1'b0;
               s2_data_q  <= '0;
            end else begin
               s2_valid_q <= s2_valid_d;
               s2_col_q   <= s2_col_d;
               s2_data_q  <= s2_data_d;
            end
         end

         assign rd_valid  = s2_valid_q;
         assign collision = s2_col_q;
         assign rd_data   = s2_data_q;
      end else begin : g_lat1
         assign rd_valid  = s1_valid_q;
         assign collision = s1_col_q;
         assign rd_data   = s1_data_q;
      end
   endgenerate

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Scoreboard bench: two instances (latency 1 / old-data, latency 2 / new-data) driven in parallel.
module tb_dual_port_ram_be;

   typedef struct {
      logic [31:0] data;
      logic        col;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic        rd_en;
   logic [3:0]  rd_addr;

   logic        busy0, busy1;
   logic [31:0] rd_data0, rd_data1;
   logic        rd_valid0, rd_valid1;
   logic        collision0, collision1;

   int   checks;
   int   fails;
   int   cyc;
   int   busy_run;
   int   last_run;
   exp_t q0[$];
   exp_t q1[$];

   dual_port_ram_be dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .busy      (busy0),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_be     (wr_be),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data0),
      .rd_valid  (rd_valid0),
      .collision (collision0)
   );

   dual_port_ram_be #(
      .RD_LATENCY (2),
      .RDW_MODE   (1)
   ) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .busy      (busy1),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_be     (wr_be),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data1),
      .rd_valid  (rd_valid1),
      .collision (collision1)
   );

   // Free-running clock and a cycle counter used to time-stamp expected responses
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
      end
   endtask

   task automatic applyStimulus(input logic c, input logic we, input logic [3:0] wa,
                                input logic [31:0] wd, input logic [3:0] be,
                                input logic re, input logic [3:0] ra);
      @(posedge clk);
      #1;
      clr     = c;
      wr_en   = we;
      wr_addr = wa;
      wr_data = wd;
      wr_be   = be;
      rd_en   = re;
      rd_addr = ra;
   endtask

   // Expected read results, stamped with the cycle on which rd_valid must appear
   task automatic expectRead(input logic [31:0] e0, input logic [31:0] e1, input logic ec);
      exp_t e;
      e.data = e0; e.col = ec; e.cyc = cyc + 1;
      q0.push_back(e);
      e.data = e1; e.col = ec; e.cyc = cyc + 2;
      q1.push_back(e);
   endtask

   task automatic doRead(input logic [3:0] ra, input logic [31:0] e0, input logic [31:0] e1);
      applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, ra);
      expectRead(e0, e1, 1'b0);
   endtask

   task automatic doWrite(input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] be);
      applyStimulus(1'b0, 1'b1, wa, wd, be, 1'b0, 4'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
   endtask

   task automatic waitReady();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy0 || busy1) && n < 200);
      if (busy0 || busy1) begin
         checks++;
         fails++;
         $display("[TB] FAIL wait_ready: busy still high after %0d cycles, expected low", n);
      end
      #1;
   endtask

   // Length of the most recent busy pulse, measured only while out of reset
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_run = 0;
      end else if (busy0) begin
         busy_run = busy_run + 1;
      end else if (busy_run != 0) begin
         last_run = busy_run;
         busy_run = 0;
      end
   end

   // Monitor for the latency-1 / old-data instance
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && rd_valid0) begin
         if (q0.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL dut0_unexpected_rd_valid: got rd_valid=1 data 0x%08h, expected none", rd_data0);
         end else begin
            e = q0.pop_front();
            checkOutput("dut0_rd_data", rd_data0, e.data);
            checkOutput("dut0_collision", {31'd0, collision0}, {31'd0, e.col});
            checkOutput("dut0_valid_cycle", 32'(cyc), 32'(e.cyc));
         end
      end else if (rst_n && collision0) begin
         checks++;
         fails++;
         $display("[TB] FAIL dut0_stray_collision: got 1 without rd_valid, expected 0");
      end
   end

   // Monitor for the latency-2 / new-data instance
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && rd_valid1) begin
         if (q1.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL dut1_unexpected_rd_valid: got rd_valid=1 data 0x%08h, expected none", rd_data1);
         end else begin
            e = q1.pop_front();
            checkOutput("dut1_rd_data", rd_data1, e.data);
            checkOutput("dut1_collision", {31'd0, collision1}, {31'd0, e.col});
            checkOutput("dut1_valid_cycle", 32'(cyc), 32'(e.cyc));
         end
      end else if (rst_n && collision1) begin
         checks++;
         fails++;
         $display("[TB] FAIL dut1_stray_collision: got 1 without rd_valid, expected 0");
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks   = 0;
      fails    = 0;
      cyc      = 0;
      busy_run = 0;
      last_run = 0;
      rst_n    = 1'b0;
      clr      = 1'b0;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      wr_be    = '0;
      rd_en    = 1'b0;
      rd_addr  = '0;

      // Reset values, then the clear pass that follows release
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_busy0", {31'd0, busy0}, 32'd1);
      checkOutput("reset_busy1", {31'd0, busy1}, 32'd1);
      checkOutput("reset_rd_valid0", {31'd0, rd_valid0}, 32'd0);
      checkOutput("reset_rd_data0", rd_data0, 32'd0);
      checkOutput("reset_rd_data1", rd_data1, 32'd0);
      checkOutput("reset_collision0", {31'd0, collision0}, 32'd0);
      rst_n = 1'b1;
      waitReady();
      checkOutput("busy_cycles_after_reset", 32'(last_run), 32'd16);

      for (int i = 0; i < 16; i++) doRead(4'(i), 32'h0, 32'h0);
      idle(3);

      // Partial-lane write, full write, then read back
      doWrite(4'd3, 32'hAABBCCDD, 4'b0101);
      doWrite(4'd5, 32'h11111111, 4'b1111);
      doRead(4'd3, 32'h00BB00DD, 32'h00BB00DD);
      doRead(4'd5, 32'h11111111, 32'h11111111);

      // Zero byte-enable write to the read address: no change, no collision
      applyStimulus(1'b0, 1'b1, 4'd3, 32'hFFFFFFFF, 4'b0000, 1'b1, 4'd3);
      expectRead(32'h00BB00DD, 32'h00BB00DD, 1'b0);

      // Full and partial same-address collisions
      applyStimulus(1'b0, 1'b1, 4'd5, 32'h22222222, 4'b1111, 1'b1, 4'd5);
      expectRead(32'h11111111, 32'h22222222, 1'b1);
      applyStimulus(1'b0, 1'b1, 4'd3, 32'h12345678, 4'b1000, 1'b1, 4'd3);
      expectRead(32'h00BB00DD, 32'h12BB00DD, 1'b1);
      doRead(4'd5, 32'h22222222, 32'h22222222);
      doRead(4'd3, 32'h12BB00DD, 32'h12BB00DD);

      // Write and read to different addresses in one cycle
      applyStimulus(1'b0, 1'b1, 4'd1, 32'h01010101, 4'b1111, 1'b1, 4'd5);
      expectRead(32'h22222222, 32'h22222222, 1'b0);
      doWrite(4'd2, 32'h02020202, 4'b1111);

      // Back-to-back reads
      doRead(4'd1, 32'h01010101, 32'h01010101);
      doRead(4'd2, 32'h02020202, 32'h02020202);
      doRead(4'd3, 32'h12BB00DD, 32'h12BB00DD);
      idle(4);
      checkOutput("hold_rd_data0", rd_data0, 32'h12BB00DD);
      checkOutput("hold_rd_data1", rd_data1, 32'h12BB00DD);

      // Clear with reads in flight; requests while busy must be dropped
      doRead(4'd1, 32'h01010101, 32'h01010101);
      applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd2);
      expectRead(32'h02020202, 32'h02020202, 1'b0);
      applyStimulus(1'b0, 1'b1, 4'd3, 32'hFFFFFFFF, 4'b1111, 1'b1, 4'd3);
      checkOutput("busy_after_clr", {31'd0, busy0}, 32'd1);
      applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd4);
      idle(1);
      waitReady();
      checkOutput("busy_cycles_after_clr", 32'(last_run), 32'd16);
      for (int i = 0; i < 16; i++) doRead(4'(i), 32'h0, 32'h0);
      idle(3);

      // Reset asserted at counter 7 of a clear pass
      doWrite(4'd4, 32'hDEADBEEF, 4'b1111);
      doRead(4'd4, 32'hDEADBEEF, 32'hDEADBEEF);
      idle(3);
      applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
      idle(8);
      rst_n = 1'b0;
      #1;
      checkOutput("midclear_reset_busy0", {31'd0, busy0}, 32'd1);
      checkOutput("midclear_reset_rd_data0", rd_data0, 32'd0);
      checkOutput("midclear_reset_rd_data1", rd_data1, 32'd0);
      checkOutput("midclear_reset_rd_valid1", {31'd0, rd_valid1}, 32'd0);
      checkOutput("midclear_reset_collision1", {31'd0, collision1}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      waitReady();
      checkOutput("busy_cycles_after_midclear_reset", 32'(last_run), 32'd16);
      doRead(4'd4, 32'h0, 32'h0);
      doRead(4'd0, 32'h0, 32'h0);
      idle(5);

      checkOutput("dut0_pending_reads", 32'(q0.size()), 32'd0);
      checkOutput("dut1_pending_reads", 32'(q1.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
